align_pipe: RTL
===============

Name: align_pipe

Overview:
- Pipelined, parametrised addend aligner for the FMA datapath.
- Right-shifts significand C into the 3*(SIG_WIDTH+1)+7-bit alignment window, saturates oversized shift amounts and computes the shifted-out sticky bit.
- Carries a sideband tag with each operand.
- Sits between exponent-difference logic and the adder, with a valid/ready handshake on both sides and a configurable number of pipeline stages.

Parameters:
- SIG_WIDTH, 23, stored fraction bits; C is SIG_WIDTH+1 bits.
- SHAMT_WIDTH, 7, width of shift amount.
- STAGES, 2, pipeline register stages (legal 1..3); latency in cycles.
- TAG_WIDTH, 4, sideband tag width; tag is carried unmodified.
- Derived, not overridable:
  - AW = 3*(SIG_WIDTH+1)+7, window width (79 at default).
  - LSBPAD = 2*(SIG_WIDTH+1)+6 (54 at default).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block accepts input this cycle.
- in_c  in  SIG_WIDTH+1  significand incl. hidden bit.
- in_shamt  in  SHAMT_WIDTH  right-shift amount.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts output.
- out_c_aligned  out  AW  aligned significand.
- out_sticky  out  1  OR of all C bits shifted below window bit 0.
- out_tag  out  TAG_WIDTH  tag of the operand on the output.

Behaviour:
- Window contents: the pre-shift window is {1'b0, in_c, LSBPAD zeros}. out_c_aligned = window >> eff_shamt, where eff_shamt = min(in_shamt, AW).
- Sticky:
  - in_c[j] sits at window bit LSBPAD+j and is shifted out when eff_shamt > LSBPAD+j.
  - out_sticky = OR of in_c[j] over every j with LSBPAD+j < eff_shamt.
  - Hence out_sticky = 0 for eff_shamt <= LSBPAD.
  - eff_shamt = AW gives out_c_aligned = 0 and out_sticky = |in_c.
- Pipeline enable: adv = out_ready | ~out_valid. in_ready = adv (combinational).
- Input transfer: occurs when in_valid & in_ready. Stage-1 valid loads in_valid & adv.
- Stall: when adv = 0, every stage register and every valid bit holds, and outputs are stable.
- Bubbles are not collapsed while stalled; the pipeline moves only as a whole.
- Shifter split: the shift is divided across the STAGES registers (choice of shamt-bit grouping is free). Sticky is computed in parallel with the shift. Tag and sticky travel with the data.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stall.
- Throughput: 1 operand/cycle while out_ready = 1.
- Output transfer: occurs when out_valid & out_ready.
- Reset (async assert, sync-safe deassert handled upstream):
  - All valid bits = 0, out_c_aligned = 0, out_sticky = 0, out_tag = 0.
  - in_ready = 1 after reset (out_valid = 0).
  - Reset mid-operation discards every in-flight operand; nothing is emitted afterwards for them.
- Data-path registers need no reset for function but are reset so outputs read 0 when out_valid = 0 after reset.
- X on in_c or in_shamt when in_valid = 0 must not propagate to out_valid.

Optional Feature:
- Macro ALIGN_NEG_EN.
- When defined:
  - Adds input in_sub (1, travels with operand) and output out_cin (1).
  - If sub = 1, out_c_aligned is the bitwise inverse of the aligned window.
  - out_cin = sub & ~sticky, the two's-complement increment for the adder carry-in.
  - out_sticky is unchanged by inversion.
  - out_cin resets to 0.
- When undefined: ports in_sub and out_cin do not exist, and there is no inversion logic.

Test Plan:
- Default params, in_c=0x800000, shamt=0, out_ready=1 -> after 2 cycles out_c_aligned has only bit 77 set, sticky=0.
- in_c=0xFFFFFF, shamt=55 -> sticky=1, out_c_aligned = 0x7FFFFF in bits [22:0]. in_c=0xFFFFFE, shamt=55 -> sticky=0.
- Saturation:
  - shamt=127 with in_c=0x000001 -> out_c_aligned=0, sticky=1.
  - shamt=79 with in_c=0 -> out_c_aligned=0, sticky=0.
- Back-to-back with out_ready low: send 5 operands, tags 0..4, while out_ready toggles 1,0,0,1,... -> in_ready tracks adv, outputs hold stable while stalled, tags emerge 0..4 in order, none lost or duplicated.
- Reset: assert rst_n=0 with 2 operands in flight -> out_valid=0 immediately and all outputs 0; after release the first new operand emerges STAGES cycles after acceptance.
- With ALIGN_NEG_EN: in_c=0x800000, shamt=0, sub=1 -> out_c_aligned = ~(1<<77) over 79 bits, sticky=0, out_cin=1. Same with shamt=100, in_c=1 -> sticky=1, out_cin=0.

Source files
------------

// File: rtl/align_pipe.sv
// Pipelined addend aligner: right-shifts C into the FMA alignment window with saturation and sticky.
// Optional ALIGN_NEG_EN adds in_sub/out_cin and inverts the aligned window for subtraction.
module align_pipe #(
   parameter int unsigned SIG_WIDTH   = 23,
   parameter int unsigned SHAMT_WIDTH = 7,
   parameter int unsigned STAGES      = 2,
   parameter int unsigned TAG_WIDTH   = 4,
   localparam int unsigned AW         = 3*(SIG_WIDTH+1)+7,
   localparam int unsigned LSBPAD     = 2*(SIG_WIDTH+1)+6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SIG_WIDTH:0]     in_c,
   input  logic [SHAMT_WIDTH-1:0] in_shamt,
   input  logic [TAG_WIDTH-1:0]   in_tag,
`ifdef ALIGN_NEG_EN
   input  logic                   in_sub,
   output logic                   out_cin,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AW-1:0]          out_c_aligned,
   output logic                   out_sticky,
   output logic [TAG_WIDTH-1:0]   out_tag
);

   localparam int unsigned EW = $clog2(AW+1);

   // Stage k applies the shift bits whose index is congruent to k modulo STAGES.
   function automatic logic [EW-1:0] stage_mask(input int unsigned k);
      stage_mask = '0;
      for (int unsigned b = 0; b < EW; b++) begin
         if (b % STAGES == k) stage_mask[b] = 1'b1;
      end
   endfunction

   logic                 r_vld [STAGES];
   logic [AW-1:0]        r_win [STAGES];
   logic [EW-1:0]        r_sh  [STAGES];
   logic                 r_st  [STAGES];
   logic [TAG_WIDTH-1:0] r_tag [STAGES];

   logic                 w_src_vld [STAGES];
   logic [AW-1:0]        w_src_win [STAGES];
   logic [EW-1:0]        w_src_sh  [STAGES];
   logic                 w_src_st  [STAGES];
   logic [TAG_WIDTH-1:0] w_src_tag [STAGES];
   logic [AW-1:0]        w_nxt_win [STAGES];

   logic                 w_adv;
   logic [EW-1:0]        w_eff;
   logic                 w_sticky;
   logic                 w_unused_sh;

`ifdef ALIGN_NEG_EN
   logic                 r_sub     [STAGES];
   logic                 w_src_sub [STAGES];
`endif

   assign w_adv       = out_ready | ~r_vld[STAGES-1];
   assign in_ready    = w_adv;
   assign w_unused_sh = ^r_sh[STAGES-1];

   always_comb begin
      w_eff = (32'(in_shamt) >= AW) ? EW'(AW) : EW'(in_shamt);
      // Sticky is resolved from the saturated amount up front, in parallel with the shift.
      w_sticky = 1'b0;
      for (int unsigned j = 0; j <= SIG_WIDTH; j++) begin
         if (LSBPAD + j < 32'(w_eff)) w_sticky = w_sticky | in_c[j];
      end
   end

   always_comb begin
      w_src_vld[0] = in_valid;
      w_src_win[0] = {1'b0, in_c, {LSBPAD{1'b0}}};
      w_src_sh[0]  = w_eff;
      w_src_st[0]  = w_sticky;
      w_src_tag[0] = in_tag;
`ifdef ALIGN_NEG_EN
      w_src_sub[0] = in_sub;
`endif
      for (int unsigned k = 1; k < STAGES; k++) begin
         w_src_vld[k] = r_vld[k-1];
         w_src_win[k] = r_win[k-1];
         w_src_sh[k]  = r_sh[k-1];
         w_src_st[k]  = r_st[k-1];
         w_src_tag[k] = r_tag[k-1];
`ifdef ALIGN_NEG_EN
         w_src_sub[k] = r_sub[k-1];
`endif
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
         w_nxt_win[k] = w_src_win[k] >> (w_src_sh[k] & stage_mask(k));
`ifdef ALIGN_NEG_EN
         if (k == STAGES-1) w_nxt_win[k] = w_nxt_win[k] ^ {AW{w_src_sub[k]}};
`endif
      end
   end

   // The whole pipe advances or holds together; bubbles are not squeezed out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_win[k] <= '0;
            r_sh[k]  <= '0;
            r_st[k]  <= 1'b0;
            r_tag[k] <= '0;
`ifdef ALIGN_NEG_EN
            r_sub[k] <= 1'b0;
`endif
         end
      end else if (w_adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_vld[k] <= w_src_vld[k];
            r_win[k] <= w_nxt_win[k];
            r_sh[k]  <= w_src_sh[k];
            r_st[k]  <= w_src_st[k];
            r_tag[k] <= w_src_tag[k];
`ifdef ALIGN_NEG_EN
            r_sub[k] <= w_src_sub[k];
`endif
         end
      end
   end

   assign out_valid     = r_vld[STAGES-1];
   assign out_c_aligned = r_win[STAGES-1];
   assign out_sticky    = r_st[STAGES-1];
   assign out_tag       = r_tag[STAGES-1];
`ifdef ALIGN_NEG_EN
   assign out_cin       = r_sub[STAGES-1] & ~r_st[STAGES-1];
`endif

endmodule
